// File: rtl/sg1_pkg.sv
// Shared SG1 types and HC-SR04 timing defaults, used by the ranger and by the bench sensor model.
package sg1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } sonar_st_t;

    localparam int unsigned HCSR04_TRIG_US     = 10;
    localparam int unsigned HCSR04_RISE_TO_US  = 5000;
    localparam int unsigned HCSR04_ECHO_MAX_US = 38000;
    localparam int unsigned HCSR04_PERIOD_US   = 60000;
    localparam int unsigned HCSR04_US_PER_CM   = 58;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input (echo, key_n, uart_rx).
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sonar_ranger.sv
// HC-SR04 ranging controller: trigger pulse, echo width in us, floor(us/US_PER_CM) in cm.
// state        | meaning
// ST_IDLE      | waiting for start
// ST_TRIG      | trigger pin high for TRIG_US cycles
// ST_WAIT_RISE | waiting for echo rise, bounded by RISE_TO_US
// ST_MEASURE   | counting echo width, aborted at ECHO_MAX_US
// ST_HOLDOFF   | enforcing PERIOD_US between triggers
module sonar_ranger
    import sg1_pkg::*;
#(
    parameter int unsigned TRIG_US     = HCSR04_TRIG_US,
    parameter int unsigned RISE_TO_US  = HCSR04_RISE_TO_US,
    parameter int unsigned ECHO_MAX_US = HCSR04_ECHO_MAX_US,
    parameter int unsigned PERIOD_US   = HCSR04_PERIOD_US,
    parameter int unsigned US_PER_CM   = HCSR04_US_PER_CM
) (
    input  logic        clk_1m,
    input  logic        rst,
    input  logic        start,
    input  logic        s1_echo,
    output logic        s1_trig,
    output logic        busy,
    output logic [15:0] dist_us,
    output logic [9:0]  dist_cm,
    output logic        dist_vld,
    output logic        err
);

    localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
    localparam logic [15:0] RISE_LAST = 16'(RISE_TO_US - 1);
    localparam logic [15:0] ECHO_MAX  = 16'(ECHO_MAX_US);
    localparam logic [15:0] PER_LAST  = 16'(PERIOD_US - 1);
    localparam logic [15:0] PRE_LAST  = 16'(US_PER_CM - 1);

    sonar_st_t   state_q, state_d;
    logic [15:0] tmr_q, tmr_d, per_q, per_d, us_q, us_d, pre_q, pre_d;
    logic [9:0]  cm_q, cm_d;
    logic [15:0] us_nxt, pre_nxt;
    logic [9:0]  cm_nxt;
    logic        echo_s, echo_q, echo_rise, echo_fall;
    logic        wait_tout, meas_tout, meas_done;
    logic        trig_q, trig_d, busy_q, busy_d, vld_q, vld_d, err_q, err_d;
    logic [15:0] dist_us_q, dist_us_d;
    logic [9:0]  dist_cm_q, dist_cm_d;

    sync2 u_sync_echo (
        .clk_i (clk_1m),
        .rst_i (rst),
        .d_i   (s1_echo),
        .q_o   (echo_s)
    );

    assign echo_rise = echo_s & ~echo_q;
    assign echo_fall = ~echo_s & echo_q;

    // Counting on echo_q spans rise detection through fall detection, so the width is exact.
    always_comb begin
        us_nxt  = us_q + 16'(echo_q);
        pre_nxt = pre_q;
        cm_nxt  = cm_q;
        if (echo_q) begin
            if (pre_q == PRE_LAST) begin
                pre_nxt = '0;
                cm_nxt  = cm_q + 10'd1;
            end else begin
                pre_nxt = pre_q + 16'd1;
            end
        end
    end

    assign wait_tout = (state_q == ST_WAIT_RISE) && !echo_rise && (tmr_q == '0);
    assign meas_tout = (state_q == ST_MEASURE) && (us_nxt == ECHO_MAX);
    assign meas_done = (state_q == ST_MEASURE) && echo_fall && !meas_tout;

    always_ff @(posedge clk_1m) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            echo_q    <= 1'b0;
            tmr_q     <= '0;
            per_q     <= '0;
            us_q      <= '0;
            pre_q     <= '0;
            cm_q      <= '0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            dist_us_q <= '0;
            dist_cm_q <= '0;
        end else begin
            state_q   <= state_d;
            echo_q    <= echo_s;
            tmr_q     <= tmr_d;
            per_q     <= per_d;
            us_q      <= us_d;
            pre_q     <= pre_d;
            cm_q      <= cm_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            dist_us_q <= dist_us_d;
            dist_cm_q <= dist_cm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        per_d   = (state_q != ST_IDLE) ? per_q + 16'd1 : per_q;
        us_d    = us_q;
        pre_d   = pre_q;
        cm_d    = cm_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TRIG;
                    tmr_d   = TRIG_LAST;
                    per_d   = '0;
                end
            end
            ST_TRIG: begin
                if (tmr_q == '0) begin
                    state_d = ST_WAIT_RISE;
                    tmr_d   = RISE_LAST;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    us_d    = '0;
                    pre_d   = '0;
                    cm_d    = '0;
                end else if (tmr_q == '0) begin
                    state_d = ST_HOLDOFF;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            ST_MEASURE: begin
                us_d  = us_nxt;
                pre_d = pre_nxt;
                cm_d  = cm_nxt;
                if (meas_tout || echo_fall) begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (per_q >= PER_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        trig_d    = (state_q == ST_TRIG);
        busy_d    = (state_q != ST_IDLE);
        vld_d     = 1'b0;
        err_d     = err_q;
        dist_us_d = dist_us_q;
        dist_cm_d = dist_cm_q;
        if (wait_tout) begin
            vld_d     = 1'b1;
            err_d     = 1'b1;
            dist_us_d = '0;
            dist_cm_d = '0;
        end else if (meas_tout) begin
            vld_d     = 1'b1;
            err_d     = 1'b1;
            dist_us_d = ECHO_MAX;
            dist_cm_d = cm_nxt;
        end else if (meas_done) begin
            vld_d     = 1'b1;
            err_d     = 1'b0;
            dist_us_d = us_nxt;
            dist_cm_d = cm_nxt;
        end
    end

    assign s1_trig  = trig_q;
    assign busy     = busy_q;
    assign dist_vld = vld_q;
    assign err      = err_q;
    assign dist_us  = dist_us_q;
    assign dist_cm  = dist_cm_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger with shortened timing parameters and an inline HC-SR04 echo model.
`timescale 1ns/1ps
module tb_sonar_ranger;
    import sg1_pkg::*;

    localparam int TRIG = HCSR04_TRIG_US;
    localparam int UPC  = HCSR04_US_PER_CM;
    localparam int RISE = 300;
    localparam int EMAX = 1900;
    localparam int PER  = 2500;

    typedef struct {
        int dly;
        int w;
        int exp_err;
        int exp_us;
        int exp_cm;
        int exp_lat;
    } vec_t;

    logic        clk_1m = 1'b0;
    logic        rst;
    logic        start;
    logic        s1_echo;
    logic        s1_trig;
    logic        busy;
    logic [15:0] dist_us;
    logic [9:0]  dist_cm;
    logic        dist_vld;
    logic        err;

    sonar_ranger #(
        .TRIG_US     (TRIG),
        .RISE_TO_US  (RISE),
        .ECHO_MAX_US (EMAX),
        .PERIOD_US   (PER),
        .US_PER_CM   (UPC)
    ) dut (
        .clk_1m   (clk_1m),
        .rst      (rst),
        .start    (start),
        .s1_echo  (s1_echo),
        .s1_trig  (s1_trig),
        .busy     (busy),
        .dist_us  (dist_us),
        .dist_cm  (dist_cm),
        .dist_vld (dist_vld),
        .err      (err)
    );

    always #500 clk_1m = ~clk_1m;

    int cyc = 0;
    always @(posedge clk_1m) cyc <= cyc + 1;

    int   rise_q[$];
    int   fall_cnt = 0, fall_cyc = 0, trig_w = 0;
    int   vld_cnt = 0, vld_cyc = 0, vld_us = 0, vld_cm = 0, vld_err = 0;
    logic trig_prev = 1'b0;

    always @(negedge clk_1m) begin
        if (s1_trig && !trig_prev) rise_q.push_back(cyc);
        if (!s1_trig && trig_prev && rise_q.size() > 0) begin
            fall_cnt <= fall_cnt + 1;
            fall_cyc <= cyc;
            trig_w   <= cyc - rise_q[rise_q.size() - 1];
        end
        trig_prev <= s1_trig;
        if (dist_vld) begin
            vld_cnt <= vld_cnt + 1;
            vld_cyc <= cyc;
            vld_us  <= int'(dist_us);
            vld_cm  <= int'(dist_cm);
            vld_err <= int'(err);
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp_v, input int tol);
        n_vec++;
        if (act > exp_v + tol || act < exp_v - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp_v, tol);
        end
    endtask

    task automatic wait_fall(input int f0, input string tag);
        int n = 0;
        while (fall_cnt == f0 && n < 200) begin
            @(negedge clk_1m);
            n++;
        end
        if (fall_cnt == f0) begin
            n_bad++;
            $display("FAIL %s: trigger fall not seen in %0d cycles, want one", tag, n);
        end
    endtask

    task automatic wait_vld(input int v0, input int budget, input string tag);
        int n = 0;
        while (vld_cnt == v0 && n < budget) begin
            @(negedge clk_1m);
            n++;
        end
        if (vld_cnt == v0) begin
            n_bad++;
            $display("FAIL %s: dist_vld not seen in %0d cycles, want one", tag, n);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk_1m);
            n++;
        end
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: busy still %b after %0d cycles, want 0", tag, busy, n);
        end
    endtask

    task automatic run_meas(input vec_t v, input string tag);
        int tr0, f0, v0, c0;
        tr0 = rise_q.size();
        f0  = fall_cnt;
        v0  = vld_cnt;
        @(negedge clk_1m);
        c0    = cyc;
        start = 1'b1;
        @(negedge clk_1m);
        start = 1'b0;
        wait_fall(f0, tag);
        if (rise_q.size() > tr0) chk({tag, "_trig_lat"}, rise_q[tr0] - c0, 2, 0);
        else chk({tag, "_trig_seen"}, rise_q.size() - tr0, 1, 0);
        chk({tag, "_trig_w"}, trig_w, TRIG, 0);
        if (v.w > 0) begin
            repeat (v.dly) @(negedge clk_1m);
            s1_echo = 1'b1;
            repeat (v.w) @(negedge clk_1m);
            s1_echo = 1'b0;
        end
        wait_vld(v0, RISE + EMAX + 100, tag);
        if (v.exp_lat >= 0) chk({tag, "_rise_to_lat"}, vld_cyc - fall_cyc, v.exp_lat, 1);
        wait_idle(PER + 100, tag);
        repeat (3) @(negedge clk_1m);
        chk({tag, "_vld_cnt"}, vld_cnt - v0, 1, 0);
        chk({tag, "_err"}, vld_err, v.exp_err, 0);
        chk({tag, "_us"}, vld_us, v.exp_us, 1);
        chk({tag, "_cm"}, vld_cm, v.exp_cm, 0);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vec_t nom;
        int   tr0, v0;

        vecs[0] = '{dly: 20, w: 580,  exp_err: 0, exp_us: 580,  exp_cm: 10, exp_lat: -1};
        vecs[1] = '{dly: 20, w: 115,  exp_err: 0, exp_us: 115,  exp_cm: 1,  exp_lat: -1};
        vecs[2] = '{dly: 20, w: 57,   exp_err: 0, exp_us: 57,   exp_cm: 0,  exp_lat: -1};
        vecs[3] = '{dly: 5,  w: 116,  exp_err: 0, exp_us: 116,  exp_cm: 2,  exp_lat: -1};
        vecs[4] = '{dly: 20, w: 1,    exp_err: 0, exp_us: 1,    exp_cm: 0,  exp_lat: -1};
        vecs[5] = '{dly: 20, w: 1899, exp_err: 0, exp_us: 1899, exp_cm: 32, exp_lat: -1};
        vecs[6] = '{dly: 20, w: 1900, exp_err: 1, exp_us: 1900, exp_cm: 32, exp_lat: -1};
        vecs[7] = '{dly: 0,  w: 0,    exp_err: 1, exp_us: 0,    exp_cm: 0,  exp_lat: RISE};
        vecs[8] = '{dly: 20, w: 2200, exp_err: 1, exp_us: 1900, exp_cm: 32, exp_lat: -1};

        rst     = 1'b1;
        start   = 1'b0;
        s1_echo = 1'b0;
        repeat (3) @(negedge clk_1m);
        rst = 1'b0;
        chk("rst_trig", int'(s1_trig), 0, 0);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_us", int'(dist_us), 0, 0);
        chk("rst_cm", int'(dist_cm), 0, 0);
        chk("rst_vld", int'(dist_vld), 0, 0);
        chk("rst_err", int'(err), 0, 0);

        for (int i = 0; i < 9; i++) run_meas(vecs[i], $sformatf("v%0d", i));

        // start held high: one trigger per period, no queuing beyond that
        tr0 = rise_q.size();
        @(negedge clk_1m);
        start = 1'b1;
        repeat (9000) @(negedge clk_1m);
        start = 1'b0;
        wait_idle(PER + 100, "b2b");
        repeat (3) @(negedge clk_1m);
        chk("b2b_trig_cnt", rise_q.size() - tr0, 4, 0);
        for (int k = 1; k < 4; k++) begin
            if (rise_q.size() > tr0 + k)
                chk($sformatf("b2b_gap%0d", k), rise_q[tr0 + k] - rise_q[tr0 + k - 1], PER + 1, 1);
        end

        // start pulses while busy are dropped
        tr0 = rise_q.size();
        v0  = vld_cnt;
        @(negedge clk_1m);
        start = 1'b1;
        @(negedge clk_1m);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (100) @(negedge clk_1m);
            start = 1'b1;
            @(negedge clk_1m);
            start = 1'b0;
        end
        wait_idle(PER + 100, "ign");
        repeat (20) @(negedge clk_1m);
        chk("ign_trig_cnt", rise_q.size() - tr0, 1, 0);
        chk("ign_vld_cnt", vld_cnt - v0, 1, 0);

        // reset 300 us into the echo
        v0 = vld_cnt;
        @(negedge clk_1m);
        start = 1'b1;
        @(negedge clk_1m);
        start = 1'b0;
        wait_fall(fall_cnt, "mrst");
        repeat (20) @(negedge clk_1m);
        s1_echo = 1'b1;
        repeat (300) @(negedge clk_1m);
        rst = 1'b1;
        @(negedge clk_1m);
        rst = 1'b0;
        chk("mrst_trig", int'(s1_trig), 0, 0);
        chk("mrst_busy", int'(busy), 0, 0);
        chk("mrst_vld", int'(dist_vld), 0, 0);
        chk("mrst_us", int'(dist_us), 0, 0);
        chk("mrst_cm", int'(dist_cm), 0, 0);
        chk("mrst_err", int'(err), 0, 0);
        repeat (50) @(negedge clk_1m);
        s1_echo = 1'b0;
        repeat (50) @(negedge clk_1m);
        chk("mrst_no_vld", vld_cnt - v0, 0, 0);
        nom = '{dly: 20, w: 580, exp_err: 0, exp_us: 580, exp_cm: 10, exp_lat: -1};
        run_meas(nom, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sonar_ranger.md
# sonar_ranger

Ranging controller for the HC-SR04 ultrasonic sensor on the `s1_trig`/`s1_echo` pins of the SG1 top. On a start request it issues the trigger pulse, times the echo pulse in microseconds, and converts the width to centimetres. It reports each result, or a timeout error, with a one-cycle valid strobe for the UART reporting path. It is the initiator for the sensor; the bench `hc_sr04` model is the responder.

## Interface
Parameters:
- `TRIG_US`, 10: trigger high time, in clk_1m cycles.
- `RISE_TO_US`, 5000: maximum wait from trigger fall to echo rise.
- `ECHO_MAX_US`, 38000: echo width at which the measurement is aborted as a timeout.
- `PERIOD_US`, 60000: minimum spacing between trigger rising edges.
- `US_PER_CM`, 58: echo microseconds per centimetre.

Ports:
- `clk_1m` in 1: 1 MHz clock. One cycle is 1 µs.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request one measurement. Sampled only in IDLE.
- `s1_echo` in 1: sensor echo, asynchronous.
- `s1_trig` out 1: sensor trigger. Registered output.
- `busy` out 1: high in every state except IDLE.
- `dist_us` out 16: last echo width, in µs.
- `dist_cm` out 10: last distance, in cm.
- `dist_vld` out 1: one-cycle strobe when `dist_*`/`err` are updated.
- `err` out 1: the last measurement timed out. Set and cleared only together with `dist_vld`.

## Operation
- `s1_echo` passes through a 2-FF synchronizer giving `echo_s`. `echo_s` is registered once more to detect edges.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: when `start`=1, go to TRIG and clear the period counter. `start` is ignored in every other state and is not queued.
- TRIG: `s1_trig`=1 for exactly `TRIG_US` cycles, then go to WAIT_RISE with the wait counter cleared.
- WAIT_RISE: a rising `echo_s` goes to MEASURE with `us_cnt`=0, `cm_cnt`=0 and `pre`=0. If `RISE_TO_US` cycles elapse first, report `err`=1, `dist_us`=0, `dist_cm`=0 and go to HOLDOFF.
- MEASURE: each cycle with `echo_s`=1, `us_cnt`+1. `pre` counts modulo `US_PER_CM`, and each wrap increments `cm_cnt`, so `cm_cnt` = floor(us/58) without a divider.
- MEASURE, falling `echo_s`: latch `dist_us`=`us_cnt` and `dist_cm`=`cm_cnt`, set `err`=0, pulse `dist_vld`, go to HOLDOFF.
- MEASURE, `us_cnt` reaching `ECHO_MAX_US`: latch `dist_us`=`ECHO_MAX_US` and `dist_cm`=`cm_cnt`, set `err`=1, pulse `dist_vld`, go to HOLDOFF.
- HOLDOFF: wait until the period counter, running since TRIG entry, reaches `PERIOD_US`-1, then go to IDLE. If the echo is still high on a timeout, HOLDOFF covers the remainder; a late falling edge is ignored.
- Width rules: `us_cnt` is 16 bits and never wraps, because it saturates at `ECHO_MAX_US`. `cm_cnt` is 10 bits (max 655).

## Timing
- Reset values: `s1_trig`=0, `busy`=0, `dist_us`=0, `dist_cm`=0, `dist_vld`=0, `err`=0. The FSM is in IDLE and all counters are 0.
- `start` sampled high at edge N: `s1_trig` and `busy` go high after edge N+1. `s1_trig` falls after edge N+1+`TRIG_US`.
- Echo input to internal detection takes 2 cycles of synchronizer latency plus 1 edge-register cycle. The rise and fall paths have equal latency, so the measured width equals the true width ±1.
- `dist_vld` is high for the cycle after the fall is detected. `dist_*` hold their value until the next `dist_vld`.
- Trigger-to-trigger spacing is at least `PERIOD_US` cycles, even with `start` held high continuously.
- `rst` asserted mid-measurement: at the next edge all outputs return to their reset values and no `dist_vld` is produced.
- An echo already high when WAIT_RISE is entered is not counted; a rising edge is required.

## Structure
- Shared package `sg1_pkg`: FSM state enum `sonar_st_t` and default timing constants (`HCSR04_TRIG_US`, `HCSR04_US_PER_CM`, etc.), which are reused by the bench model.
- One sub-module `sync2`: the 2-FF synchronizer, which is reusable for `key_n` and `uart_rx`.
- Everything else is a single FSM with its counters in `sonar_ranger`.

## Test plan
- Nominal: `start` pulse; model echo = 580 µs. Expect `s1_trig` high for 10 cycles, then `dist_vld` with `dist_us`=580±1, `dist_cm`=10, `err`=0.
- cm floor: echo = 115 µs → `dist_cm`=1. Echo = 57 µs → `dist_cm`=0.
- No echo: model silent. `dist_vld` arrives 5000 cycles after trigger fall, with `err`=1 and `dist_us`=0. The next trigger is no sooner than 60000 cycles after the first.
- Echo stuck high: echo lasts 45000 µs → `err`=1, `dist_us`=38000, `dist_cm`=655. The late fall produces no extra strobe.
- Back-to-back: `start` held high for 200 ms → exactly 4 triggers, 60000 cycles apart. `start` pulses during `busy` are ignored.
- Reset mid-MEASURE: `rst` pulsed 300 µs into the echo → `s1_trig`=0, `busy`=0 and no `dist_vld`. A new `start` then measures correctly.
